// File: rtl/pulse_period_meter.sv
// pulse_period_meter
//
// Measures the number of clk cycles between consecutive rising edges of an
// asynchronous pulse train. Each measurement is reported with a one-cycle
// period_valid strobe. A one-cycle timeout strobe fires when no edge arrives
// before the counter would overflow. locked rises once LOCK_COUNT consecutive
// measurements have each matched their predecessor within TOLERANCE cycles.
//
// Parameters:
//   COUNT_WIDTH  width of the cycle counter and period (max period 2^W-1)
//   SYNC_STAGES  synchronizer depth on pulse_in (>= 2)
//   TOLERANCE    max |new - prev| that still counts as a match
//   LOCK_COUNT   consecutive matches needed for locked (>= 1)
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   enable        measurement enable (synchronous)
//   pulse_in      asynchronous pulse train, rising edges used
//   period        last measured period, held between measurements
//   period_valid  one-cycle strobe, period updated this cycle
//   timeout       one-cycle strobe, no edge within counter range
//   locked        period stable for LOCK_COUNT matches
module pulse_period_meter #(
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TOLERANCE   = 0,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   pulse_in,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   period_valid,
  output logic                   timeout,
  output logic                   locked
);

  localparam int unsigned MatchWidth = $clog2(LOCK_COUNT + 1);
  localparam logic [MatchWidth-1:0]  LockMax = MatchWidth'(LOCK_COUNT);
  localparam logic [COUNT_WIDTH-1:0] Tol     = COUNT_WIDTH'(TOLERANCE);
  // Last count value before cnt + 1 would reach the all-ones maximum period.
  localparam logic [COUNT_WIDTH-1:0] CntLast = {{(COUNT_WIDTH - 1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;

  // Synchronizer and edge detect
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_dly_q;
  logic                   evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      sync_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

  // Measurement state
  state_e                  state_q;
  logic [COUNT_WIDTH-1:0]  cnt_q;
  logic [COUNT_WIDTH-1:0]  prev_q;
  logic                    prev_ok_q;
  logic [MatchWidth-1:0]   match_cnt_q;

  logic [COUNT_WIDTH-1:0]  new_period;
  logic [COUNT_WIDTH-1:0]  diff;
  logic                    is_match;
  logic [MatchWidth-1:0]   match_cnt_d;

  // Lock bookkeeping for a measurement closing this cycle
  always_comb begin
    new_period  = cnt_q + COUNT_WIDTH'(1);
    // Larger minus smaller keeps the difference in range without a sign bit.
    diff        = (new_period >= prev_q) ? (new_period - prev_q) : (prev_q - new_period);
    is_match    = prev_ok_q && (diff <= Tol);
    match_cnt_d = '0;
    if (is_match) begin
      match_cnt_d = (match_cnt_q == LockMax) ? LockMax : (match_cnt_q + MatchWidth'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      prev_q       <= '0;
      prev_ok_q    <= 1'b0;
      match_cnt_q  <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      locked       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      if (!enable) begin
        // Disable overrides any edge seen this cycle; period is kept.
        state_q     <= StIdle;
        cnt_q       <= '0;
        prev_ok_q   <= 1'b0;
        match_cnt_q <= '0;
        locked      <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StArm;
          end
          StArm: begin
            if (evt) begin
              state_q <= StMeasure;
              cnt_q   <= '0;
            end
          end
          StMeasure: begin
            // An edge on the last count wins over the timeout.
            if (evt) begin
              period       <= new_period;
              period_valid <= 1'b1;
              cnt_q        <= '0;
              prev_q       <= new_period;
              prev_ok_q    <= 1'b1;
              match_cnt_q  <= match_cnt_d;
              locked       <= (match_cnt_d == LockMax);
            end else if (cnt_q == CntLast) begin
              timeout     <= 1'b1;
              state_q     <= StArm;
              cnt_q       <= '0;
              prev_ok_q   <= 1'b0;
              match_cnt_q <= '0;
              locked      <= 1'b0;
            end else begin
              cnt_q <= cnt_q + COUNT_WIDTH'(1);
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter. Instance a: 16-bit counter,
// TOLERANCE 1, LOCK_COUNT 4. Instance b: 4-bit counter, TOLERANCE 0, LOCK_COUNT 4.
module tb_pulse_period_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_a, pin_a, en_b, pin_b;
  logic [15:0] period_a;
  logic        pv_a, to_a, lk_a;
  logic [3:0]  period_b;
  logic        pv_b, to_b, lk_b;

  pulse_period_meter #(
    .COUNT_WIDTH(16), .SYNC_STAGES(2), .TOLERANCE(1), .LOCK_COUNT(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .pulse_in(pin_a),
    .period(period_a), .period_valid(pv_a), .timeout(to_a), .locked(lk_a)
  );

  pulse_period_meter #(
    .COUNT_WIDTH(4), .SYNC_STAGES(2), .TOLERANCE(0), .LOCK_COUNT(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .pulse_in(pin_b),
    .period(period_b), .period_valid(pv_b), .timeout(to_b), .locked(lk_b)
  );

  // cyc == 0 means "any cycle"
  typedef struct {
    logic [15:0] period;
    logic        locked;
    logic        is_timeout;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic check_strobe(input string nm, input exp_t e, input logic pv, input logic to,
                              input logic [15:0] p, input logic lk);
    vectors++;
    if (pv !== !e.is_timeout || to !== e.is_timeout || p !== e.period || lk !== e.locked ||
        (e.cyc != 0 && cyc != e.cyc)) begin
      miscompares++;
      $display("FAIL %s strobe: got pv=%0b to=%0b period=%0d locked=%0b cyc=%0d, want pv=%0b to=%0b period=%0d locked=%0b cyc=%0d",
               nm, pv, to, p, lk, cyc, !e.is_timeout, e.is_timeout, e.period, e.locked, e.cyc);
    end
  endtask

  // Monitors: every strobe must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (pv_a || to_a)) begin
      if (q_a.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL a_unexpected: got pv=%0b to=%0b period=%0d, want no strobe",
                 pv_a, to_a, period_a);
      end else begin
        e = q_a.pop_front();
        check_strobe("a", e, pv_a, to_a, period_a, lk_a);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (pv_b || to_b)) begin
      if (q_b.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL b_unexpected: got pv=%0b to=%0b period=%0d, want no strobe",
                 pv_b, to_b, period_b);
      end else begin
        e = q_b.pop_front();
        check_strobe("b", e, pv_b, to_b, {12'd0, period_b}, lk_b);
      end
    end
  end

  task automatic push_a(input int p, input logic lk);
    exp_t e;
    e.period = 16'(p); e.locked = lk; e.is_timeout = 1'b0; e.cyc = 0;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int p, input logic lk, input logic is_to, input int c);
    exp_t e;
    e.period = 16'(p); e.locked = lk; e.is_timeout = is_to; e.cyc = c;
    q_b.push_back(e);
  endtask

  // One-cycle-high pulse; the next edge_* call starts exactly gap cycles later.
  task automatic edge_a(input int gap);
    pin_a = 1'b1;
    @(negedge clk);
    pin_a = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic edge_b(input int gap);
    pin_b = 1'b1;
    @(negedge clk);
    pin_b = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  // Six edges 8 cycles apart: strobes on edges 2..6, lock on edge 6.
  task automatic steady_a();
    edge_a(8);
    for (int k = 2; k <= 6; k++) begin
      push_a(8, k == 6);
      edge_a(8);
    end
  endtask

  initial begin
    rst_n = 1'b0; en_a = 1'b0; pin_a = 1'b0; en_b = 1'b0; pin_b = 1'b0;
    #1;
    check("rst_period_a", period_a, 16'd0);
    check("rst_valid_a", {15'd0, pv_a}, 16'd0);
    check("rst_timeout_a", {15'd0, to_a}, 16'd0);
    check("rst_locked_a", {15'd0, lk_a}, 16'd0);
    check("rst_period_b", {12'd0, period_b}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Steady train, then one more locked measurement
    en_a = 1'b1;
    repeat (3) @(negedge clk);
    steady_a();
    push_a(8, 1'b1);
    edge_a(4);
    // Enable drop mid-interval
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    check("drop_locked", {15'd0, lk_a}, 16'd0);
    check("drop_period", period_a, 16'd8);
    en_a = 1'b1;
    repeat (3) @(negedge clk);
    edge_a(8);
    push_a(8, 1'b0);
    edge_a(8);
    en_a = 1'b0;
    repeat (2) @(negedge clk);

    // Jitter with TOLERANCE 1: match count 0,1,2,0, never locked
    en_a = 1'b1;
    repeat (3) @(negedge clk);
    edge_a(8);
    push_a(8, 1'b0);
    edge_a(9);
    push_a(9, 1'b0);
    edge_a(8);
    push_a(8, 1'b0);
    edge_a(10);
    push_a(10, 1'b0);
    edge_a(6);
    en_a = 1'b0;
    repeat (2) @(negedge clk);

    // Async reset mid-interval while locked
    en_a = 1'b1;
    repeat (3) @(negedge clk);
    steady_a();
    check("pre_reset_locked", {15'd0, lk_a}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_period", period_a, 16'd0);
    check("reset_locked", {15'd0, lk_a}, 16'd0);
    check("reset_valid", {15'd0, pv_a}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    steady_a();
    en_a = 1'b0;
    repeat (2) @(negedge clk);

    // b: maximum period 15 (edge coincides with last count, no timeout)
    en_b = 1'b1;
    repeat (3) @(negedge clk);
    edge_b(15);
    push_b(15, 1'b0, 1'b0, 0);
    edge_b(15);
    push_b(15, 1'b0, 1'b0, 0);
    edge_b(6);
    en_b = 1'b0;
    repeat (2) @(negedge clk);

    // b: single edge then silence. Edge driven at cycle c is sampled at c+1,
    // evt registers at c+3, timeout shows 15 cycles later at c+18.
    en_b = 1'b1;
    repeat (3) @(negedge clk);
    push_b(15, 1'b0, 1'b1, cyc + 18);
    edge_b(22);
    edge_b(5);
    push_b(5, 1'b0, 1'b0, 0);
    edge_b(6);
    en_b = 1'b0;
    repeat (10) @(negedge clk);

    check("a_pending", 16'(q_a.size()), 16'd0);
    check("b_pending", 16'(q_b.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
